spike_frame_encoder: RTL and testbench

- Producer side of the layer's spike-time interface: turns a stream of pixel intensities into per-input spike times (time-to-first-spike coding: brighter means earlier).
- Replays each frame as per-cycle spike vectors, with a time step counter driving the layer's time_val.
- Double-buffered: the next frame loads while the current frame runs, so frames stream back-to-back with no gap.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/spike_time_quantizer.sv | 34 +++
 rtl/spike_frame_encoder.sv | 153 +++++++++++++++
 tb/tb_spike_frame_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ============================================================================
// snn_pkg : shared types and defaults for the spike-time front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int NUM_SPIKES_DEF  = 64;
  localparam int TIME_PERIOD_DEF = 16;
  localparam int TW_DEF          = $clog2(TIME_PERIOD_DEF) + 1;

  typedef logic [TW_DEF-1:0] time_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_e;

  // One past the last step: a time that can never match the step counter.
  function automatic int sentinel_time(input int time_period);
    return time_period;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_time_quantizer.sv
// ============================================================================
// spike_time_quantizer : pixel intensity to time-to-first-spike (bright = early).
// Revision: 1.0
// ============================================================================
`default_nettype none

module spike_time_quantizer
  import snn_pkg::*;
#(
  parameter int PIXEL_BITS  = 8,
  parameter int TIME_PERIOD = TIME_PERIOD_DEF,
  parameter int THRESH      = 32,
  localparam int TW         = $clog2(TIME_PERIOD) + 1
) (
  input  logic [PIXEL_BITS-1:0] pix_data,
  output logic [TW-1:0]         spike_time
);

  localparam int LB    = $clog2(TIME_PERIOD);
  localparam int SHIFT = PIXEL_BITS - LB;

  localparam logic [PIXEL_BITS:0] c_thresh   = (PIXEL_BITS + 1)'(THRESH);
  localparam logic [TW-1:0]       c_sentinel = TW'(sentinel_time(TIME_PERIOD));

  logic [LB-1:0] w_q;

  assign w_q = LB'(pix_data >> SHIFT);

  // (TIME_PERIOD-1) - q is the bitwise complement of q because TIME_PERIOD is a power of two.
  assign spike_time = ({1'b0, pix_data} < c_thresh) ? c_sentinel : {1'b0, ~w_q};

endmodule

`default_nettype wire

// File: rtl/spike_frame_encoder.sv
// ============================================================================
// spike_frame_encoder : double-buffered pixel-to-spike-time frame player.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spike_frame_encoder
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES  = NUM_SPIKES_DEF,
  parameter int TIME_PERIOD = TIME_PERIOD_DEF,
  parameter int PIXEL_BITS  = 8,
  parameter int THRESH      = 32,
  localparam int TW         = $clog2(TIME_PERIOD) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIXEL_BITS-1:0]    pix_data,
  input  logic                     stall,
  output logic [NUM_SPIKES*TW-1:0] spike_times,
  output logic [TW-1:0]            time_val,
  output logic [NUM_SPIKES-1:0]    spikes_in,
  output logic                     running,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic [15:0]              frames_done
);

  localparam int IW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;

  localparam logic [TW-1:0] c_last     = TW'(TIME_PERIOD - 1);
  localparam logic [TW-1:0] c_sentinel = TW'(sentinel_time(TIME_PERIOD));
  localparam logic [IW-1:0] c_idx_last = IW'(NUM_SPIKES - 1);

  logic [TW-1:0] r_load_bank   [NUM_SPIKES];
  logic [TW-1:0] r_active_bank [NUM_SPIKES];
  logic [IW-1:0] r_idx;
  logic          r_load_full;
  logic          r_pix_ready;
  enc_state_e    r_state;
  enc_state_e    w_state_next;
  logic [TW-1:0] r_time;
  logic [TW-1:0] w_time_next;
  logic          r_frame_start;
  logic [15:0]   r_frames_done;

  logic [TW-1:0] w_pix_time;
  logic          w_hs;
  logic          w_last_step;
  logic          w_swap;

  spike_time_quantizer #(
    .PIXEL_BITS  (PIXEL_BITS),
    .TIME_PERIOD (TIME_PERIOD),
    .THRESH      (THRESH)
  ) u_quant (
    .pix_data   (pix_data),
    .spike_time (w_pix_time)
  );

  assign w_hs        = pix_valid & r_pix_ready;
  assign w_last_step = (r_state == RUN) & ~stall & (r_time == c_last);
  // Swap either starts an idle player or chains straight into the next frame.
  assign w_swap      = r_load_full & ((r_state == IDLE) | w_last_step);

  assign pix_ready   = r_pix_ready;
  assign running     = (r_state == RUN);
  assign time_val    = r_time;
  assign frame_start = r_frame_start;
  assign frame_done  = w_last_step;
  assign frames_done = r_frames_done;

  always_comb begin
    w_state_next = r_state;
    w_time_next  = r_time;
    if (w_swap) begin
      w_state_next = RUN;
      w_time_next  = '0;
    end else if ((r_state == RUN) && !stall) begin
      if (r_time == c_last) begin
        w_state_next = IDLE;
        w_time_next  = '0;
      end else begin
        w_time_next = r_time + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_time        <= '0;
      r_frame_start <= 1'b0;
      r_frames_done <= '0;
    end else begin
      r_state       <= w_state_next;
      r_time        <= w_time_next;
      r_frame_start <= w_swap;
      if (w_last_step) begin
        r_frames_done <= r_frames_done + 16'd1;
      end
    end
  end

  // A full bank blocks handshakes, so loading and swapping never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        r_load_bank[i] <= c_sentinel;
      end
      r_idx       <= '0;
      r_load_full <= 1'b0;
      r_pix_ready <= 1'b1;
    end else begin
      if (w_hs) begin
        r_load_bank[r_idx] <= w_pix_time;
        if (r_idx == c_idx_last) begin
          r_idx       <= '0;
          r_load_full <= 1'b1;
          r_pix_ready <= 1'b0;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      if (w_swap) begin
        r_load_full <= 1'b0;
        r_pix_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        r_active_bank[i] <= c_sentinel;
      end
    end else if (w_swap) begin
      r_active_bank <= r_load_bank;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SPIKES; gi++) begin : g_spike
      assign spike_times[gi*TW +: TW] = r_active_bank[gi];
      assign spikes_in[gi] = running & ~stall & (r_active_bank[gi] == r_time);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_spike_frame_encoder.sv
// ============================================================================
// tb_spike_frame_encoder : directed self-checking bench for spike_frame_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spike_frame_encoder;

  localparam int NS = 64;
  localparam int TP = 16;
  localparam int TW = 5;

  typedef struct {
    logic [7:0]    pix;
    logic [TW-1:0] exp_t;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_valid;
  logic             pix_ready;
  logic [7:0]       pix_data;
  logic             stall;
  logic [NS*TW-1:0] spike_times;
  logic [TW-1:0]    time_val;
  logic [NS-1:0]    spikes_in;
  logic             running;
  logic             frame_start;
  logic             frame_done;
  logic [15:0]      frames_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done20    = 0;

  vec_t       vecs [16];
  logic [7:0] frame_px [5][NS];

  spike_frame_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .stall       (stall),
    .spike_times (spike_times),
    .time_val    (time_val),
    .spikes_in   (spikes_in),
    .running     (running),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_wide(input string name, input logic [NS*TW-1:0] act,
                          input logic [NS*TW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [TW-1:0] model_t(input logic [7:0] p);
    if (p < 8'd32) return 5'd16;
    return 5'd15 - {1'b0, p[7:4]};
  endfunction

  function automatic logic [NS*TW-1:0] pack_frame(input int f);
    logic [NS*TW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*TW +: TW] = model_t(frame_px[f][i]);
    return v;
  endfunction

  function automatic logic [NS-1:0] exp_spk(input int f, input int t);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = (model_t(frame_px[f][i]) == TW'(t));
    return v;
  endfunction

  function automatic logic [NS*TW-1:0] all_sentinel();
    logic [NS*TW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*TW +: TW] = 5'd16;
    return v;
  endfunction

  task automatic push(input logic [7:0] p);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = p;
    while (!pix_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("push_timeout", 64'd1, 64'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_data  = 8'h55;
  endtask

  task automatic push_frame(input int f);
    for (int k = 0; k < NS; k++) push(frame_px[f][k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_valid = 1'b0;
    stall     = 1'b0;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!frame_start && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk(name, 64'd0, 64'd1);
  endtask

  initial begin
    int cycles;
    int n;
    int st_cnt;
    int bad;
    int cnt [NS];

    vecs[0]  = '{8'hFF, 5'd0};
    vecs[1]  = '{8'h80, 5'd7};
    vecs[2]  = '{8'h10, 5'd16};
    vecs[3]  = '{8'h1F, 5'd16};
    vecs[4]  = '{8'h20, 5'd13};
    vecs[5]  = '{8'h2F, 5'd13};
    vecs[6]  = '{8'h30, 5'd12};
    vecs[7]  = '{8'h40, 5'd11};
    vecs[8]  = '{8'h7F, 5'd8};
    vecs[9]  = '{8'hA0, 5'd5};
    vecs[10] = '{8'hF0, 5'd0};
    vecs[11] = '{8'hEF, 5'd1};
    vecs[12] = '{8'h00, 5'd16};
    vecs[13] = '{8'h90, 5'd6};
    vecs[14] = '{8'h5A, 5'd10};
    vecs[15] = '{8'hC3, 5'd3};
    for (int k = 0; k < NS; k++) begin
      frame_px[0][k] = vecs[k % 16].pix;
      frame_px[1][k] = 8'((k * 37 + 11) % 256);
      frame_px[2][k] = 8'((k * 53 + 200) % 256);
      frame_px[3][k] = 8'((k * 29 + 77) % 256);
      frame_px[4][k] = 8'((k * 4) % 256);
    end

    rst = 1'b1; pix_valid = 1'b0; pix_data = 8'h00; stall = 1'b0;
    #1;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_running", running, 0);
    chk("rst_time_val", time_val, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frames_done", frames_done, 0);
    chk_wide("rst_spike_times", spike_times, all_sentinel());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame encode and idle-start latency
    push_frame(0);
    chk("lat_not_running", running, 0);
    chk("lat_full_blocks", pix_ready, 0);
    @(negedge clk);
    #1;
    chk("lat_running", running, 1);
    chk("lat_time0", time_val, 0);
    chk("lat_frame_start", frame_start, 1);
    chk("lat_ready_again", pix_ready, 1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("enc_%0d", k), spike_times[k*TW +: TW], vecs[k].exp_t);
    chk_wide("enc_bank", spike_times, pack_frame(0));
    for (int c = 0; c < TP; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("run_time_%0d", c), time_val, c);
      chk($sformatf("run_done_%0d", c), frame_done, (c == TP - 1));
      chk($sformatf("run_spk_%0d", c), spikes_in, exp_spk(0, c));
      if (c == 1) chk("start_one_cycle", frame_start, 0);
    end
    @(negedge clk);
    #1;
    chk("end_idle", running, 0);
    chk("end_time0", time_val, 0);
    chk("end_frames1", frames_done, 1);
    chk_wide("end_keep_bank", spike_times, pack_frame(0));

    // Back-to-back frames with backpressure while the load bank is full
    do_reset();
    push_frame(1);
    @(negedge clk);
    stall = 1'b1;
    #1;
    chk("b2b_start", frame_start, 1);
    chk_wide("b2b_bank_a", spike_times, pack_frame(1));
    fork
      begin
        push_frame(2);
        push_frame(3);
      end
    join_none
    n = 0;
    while (pix_ready && n < 200) begin
      chk("stall_quiet", spikes_in, 0);
      chk("stall_time_hold", time_val, 0);
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("bp_full_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("bp_ready_low", pix_ready, 0);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    cycles = 0;
    while (running && cycles < 100) begin
      cycles++;
      if (cycles <= TP) chk($sformatf("bp_hold_%0d", cycles), pix_ready, 0);
      if (cycles == TP) begin
        chk("b2b_done_a", frame_done, 1);
        chk_wide("b2b_bank_a_last", spike_times, pack_frame(1));
      end
      if (cycles == TP + 1) begin
        chk("b2b_time0", time_val, 0);
        chk("b2b_start_b", frame_start, 1);
        chk_wide("b2b_bank_b", spike_times, pack_frame(2));
        chk("bp_ready_after_swap", pix_ready, 1);
      end
      @(negedge clk);
      #1;
    end
    chk("b2b_run_cycles", cycles, 2 * TP);
    chk("b2b_frames2", frames_done, 2);
    wait_start("c_start_timeout");
    chk_wide("sb_bank_c", spike_times, pack_frame(3));
    n = 0;
    while (running && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("sb_frames3", frames_done, 3);

    // Stall for three cycles at time step 5
    do_reset();
    push_frame(0);
    @(negedge clk);
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    cycles = 0;
    st_cnt = 0;
    while (running && cycles < 100) begin
      if (time_val == 5 && st_cnt < 3) begin
        stall = 1'b1;
        st_cnt++;
      end else begin
        stall = 1'b0;
      end
      #1;
      cycles++;
      if (stall) begin
        chk("stl_time5", time_val, 5);
        chk("stl_no_spike", spikes_in, 0);
      end
      for (int i = 0; i < NS; i++) cnt[i] += int'(spikes_in[i]);
      @(negedge clk);
    end
    stall = 1'b0;
    chk("stl_cycles", cycles, TP + 3);
    bad = 0;
    for (int i = 0; i < NS; i++)
      if (cnt[i] != ((model_t(frame_px[0][i]) < 5'd16) ? 1 : 0)) bad++;
    chk("stl_spike_once", bad, 0);
    chk("stl_frames1", frames_done, 1);

    // Asynchronous reset mid-run with a partial load pending
    do_reset();
    push_frame(0);
    @(negedge clk);
    done20 = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) push(frame_px[3][k]);
        done20 = 1;
      end
    join_none
    n = 0;
    while (time_val != 9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    stall = 1'b1;
    n = 0;
    while (done20 == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ar_pre_time9", time_val, 9);
    chk("ar_pre_running", running, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_running", running, 0);
    chk("ar_time0", time_val, 0);
    chk("ar_ready", pix_ready, 1);
    chk("ar_frames0", frames_done, 0);
    chk_wide("ar_bank_sentinel", spike_times, all_sentinel());
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    push_frame(4);
    @(negedge clk);
    #1;
    chk("ar_restart", frame_start, 1);
    chk_wide("ar_bank_from_idx0", spike_times, pack_frame(4));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
